// File: rtl/mcu_cmd_pkg.sv
// rtl/mcu_cmd_pkg.sv - shared types and constants for the MCU command dispatcher
package mcu_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_FORWARD = 2'd2,
    ST_DROP    = 2'd3
  } state_e;

  localparam logic [2:0] TGT_SYS = 3'd0;
  localparam logic [2:0] TGT_HID = 3'd1;
  localparam logic [2:0] TGT_SDC = 3'd2;
  localparam logic [2:0] TGT_OSD = 3'd3;

  localparam logic [7:0] NOTGT_BYTE_DEFAULT = 8'hFF;

  function automatic logic id_valid(input logic [2:0] id, input int num_targets);
    return int'(id) < num_targets;
  endfunction

endpackage

// File: rtl/mcu_cmd_dispatch_if.sv
// rtl/mcu_cmd_dispatch_if.sv - MCU-side and target-side byte bus of the dispatcher
interface mcu_cmd_dispatch_if #(
  parameter int NUM_TARGETS = 4
);

  logic                     mcu_strobe;
  logic                     mcu_start;
  logic [7:0]               mcu_din;
  logic [7:0]               mcu_dout;
  logic [NUM_TARGETS-1:0]   tgt_strobe;
  logic [NUM_TARGETS-1:0]   tgt_start;
  logic [7:0]               tgt_din;
  logic [8*NUM_TARGETS-1:0] tgt_dout;
  logic [NUM_TARGETS-1:0]   tgt_int;

  modport master (
    output mcu_strobe, mcu_start, mcu_din, tgt_dout, tgt_int,
    input  mcu_dout, tgt_strobe, tgt_start, tgt_din
  );

  modport slave (
    input  mcu_strobe, mcu_start, mcu_din, tgt_dout, tgt_int,
    output mcu_dout, tgt_strobe, tgt_start, tgt_din
  );

endinterface

// File: rtl/mcu_cmd_timeout.sv
// rtl/mcu_cmd_timeout.sv - idle counter that aborts a frame left open without strobes
module mcu_cmd_timeout
  import mcu_cmd_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy_i,
  input  logic strobe_i,
  output logic expire_o,
  output logic abort_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;

  // expire fires on the edge that would take the count to TIMEOUT-1; a strobe always wins
  always_comb begin
    expire_o = busy_i && !strobe_i && (cnt_q == CW'(TIMEOUT - 2));
    abort_d  = expire_o;
    cnt_d    = cnt_q;
    if (strobe_i || !busy_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign abort_o = abort_q;

endmodule

// File: rtl/mcu_cmd_dispatch.sv
// rtl/mcu_cmd_dispatch.sv - routes framed MCU bytes to one of NUM_TARGETS endpoints
module mcu_cmd_dispatch
  import mcu_cmd_pkg::*;
#(
  parameter int         NUM_TARGETS = 4,
  parameter int         TIMEOUT     = 1_000_000,
  parameter logic [7:0] NOTGT_BYTE  = NOTGT_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mcu_cmd_dispatch_if.slave    bus,
  output logic                 int_out_n,
  output logic                 busy,
  output logic [2:0]           sel,
  output logic                 abort
);

  state_e                 state_q, state_d;
  logic [2:0]             sel_q, sel_d;
  logic                   first_fwd_q, first_fwd_d;
  logic [NUM_TARGETS-1:0] tgt_strobe_q, tgt_strobe_d;
  logic [NUM_TARGETS-1:0] tgt_start_q, tgt_start_d;
  logic [7:0]             tgt_din_q, tgt_din_d;
  logic [7:0]             mcu_dout_q, mcu_dout_d;
  logic                   int_n_q, int_n_d;
  logic [7:0]             reply;
  logic                   expire;

  mcu_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .busy_i   (state_q != ST_IDLE),
    .strobe_i (bus.mcu_strobe),
    .expire_o (expire),
    .abort_o  (abort)
  );

  always_comb begin
    reply = NOTGT_BYTE;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (int'(sel_q) == k) begin
        reply = bus.tgt_dout[8*k +: 8];
      end
    end
  end

  // a start strobe preempts everything, including an open frame and a pending timeout
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    first_fwd_d  = first_fwd_q;
    tgt_strobe_d = '0;
    tgt_start_d  = '0;
    tgt_din_d    = tgt_din_q;
    mcu_dout_d   = (state_q == ST_FORWARD) ? reply : NOTGT_BYTE;
    int_n_d      = ~(|bus.tgt_int);

    if (bus.mcu_strobe && bus.mcu_start) begin
      state_d     = ST_SELECT;
      sel_d       = bus.mcu_din[2:0];
      first_fwd_d = 1'b0;
    end else if (expire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_SELECT: begin
          state_d     = id_valid(sel_q, NUM_TARGETS) ? ST_FORWARD : ST_DROP;
          first_fwd_d = 1'b1;
        end
        ST_FORWARD: begin
          if (bus.mcu_strobe) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
              if (int'(sel_q) == k) begin
                tgt_strobe_d[k] = 1'b1;
                tgt_start_d[k]  = first_fwd_q;
              end
            end
            tgt_din_d   = bus.mcu_din;
            first_fwd_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      first_fwd_q  <= 1'b0;
      tgt_strobe_q <= '0;
      tgt_start_q  <= '0;
      tgt_din_q    <= 8'h00;
      mcu_dout_q   <= NOTGT_BYTE;
      int_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      first_fwd_q  <= first_fwd_d;
      tgt_strobe_q <= tgt_strobe_d;
      tgt_start_q  <= tgt_start_d;
      tgt_din_q    <= tgt_din_d;
      mcu_dout_q   <= mcu_dout_d;
      int_n_q      <= int_n_d;
    end
  end

  assign bus.tgt_strobe = tgt_strobe_q;
  assign bus.tgt_start  = tgt_start_q;
  assign bus.tgt_din    = tgt_din_q;
  assign bus.mcu_dout   = mcu_dout_q;
  assign int_out_n      = int_n_q;
  assign busy           = (state_q != ST_IDLE);
  assign sel            = sel_q;

endmodule

// File: tb/tb_mcu_cmd_dispatch.sv
// tb/tb_mcu_cmd_dispatch.sv - self-checking bench for mcu_cmd_dispatch
module tb_mcu_cmd_dispatch;
  import mcu_cmd_pkg::*;

  localparam int NT = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       int_out_n, busy, abort;
  logic [2:0] sel;
  int         errors = 0;
  int         checks = 0;

  mcu_cmd_dispatch_if #(.NUM_TARGETS(NT)) bus ();

  mcu_cmd_dispatch #(.NUM_TARGETS(NT), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .int_out_n (int_out_n),
    .busy      (busy),
    .sel       (sel),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic step(input bit stb, input bit st, input logic [7:0] d);
    bus.mcu_strobe = stb;
    bus.mcu_start  = st;
    bus.mcu_din    = d;
    @(negedge clk);
    bus.mcu_strobe = 1'b0;
    bus.mcu_start  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.tgt_int  = '0;
    bus.tgt_dout = 32'h1234_5678;
    step(1'b1, 1'b1, 8'h02);
    step(1'b0, 1'b0, 8'h00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.tgt_strobe !== 4'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0000", bus.tgt_strobe); end
    checks++; if (bus.tgt_start !== 4'b0) begin errors++; $display("FAIL reset_start got %b exp 0000", bus.tgt_start); end
    checks++; if (bus.tgt_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", bus.tgt_din); end
    checks++; if (bus.mcu_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h exp ff", bus.mcu_dout); end
    checks++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL reset_int got %b exp 1", int_out_n); end
    checks++; if (sel !== 3'd0 || abort !== 1'b0) begin errors++; $display("FAIL reset_sel_abort got %0d/%b exp 0/0", sel, abort); end
    reset_n = 1'b1;
  endtask

  task automatic test_forward_basic();
    bus.tgt_dout = 32'h0000_0000;
    step(1'b1, 1'b1, 8'h00);
    checks++; if (busy !== 1'b1 || sel !== TGT_SYS || bus.tgt_strobe !== 4'b0) begin errors++;
      $display("FAIL fwd_open got busy=%b sel=%0d stb=%b exp 1/0/0000", busy, sel, bus.tgt_strobe); end
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    checks++; if (bus.tgt_strobe !== 4'b0001 || bus.tgt_start !== 4'b0001 || bus.tgt_din !== 8'h00) begin errors++;
      $display("FAIL fwd_b0 got stb=%b st=%b din=%h exp 0001/0001/00", bus.tgt_strobe, bus.tgt_start, bus.tgt_din); end
    step(1'b1, 1'b0, 8'hAA);
    checks++; if (bus.tgt_strobe !== 4'b0001 || bus.tgt_start !== 4'b0000 || bus.tgt_din !== 8'hAA) begin errors++;
      $display("FAIL fwd_b1 got stb=%b st=%b din=%h exp 0001/0000/aa", bus.tgt_strobe, bus.tgt_start, bus.tgt_din); end
    bus.tgt_dout = 32'hA1B2_C35C;
    step(1'b1, 1'b0, 8'hBB);
    checks++; if (bus.tgt_strobe !== 4'b0001 || bus.tgt_start !== 4'b0000 || bus.tgt_din !== 8'hBB) begin errors++;
      $display("FAIL fwd_b2 got stb=%b st=%b din=%h exp 0001/0000/bb", bus.tgt_strobe, bus.tgt_start, bus.tgt_din); end
    checks++; if (bus.mcu_dout !== 8'h5C) begin errors++; $display("FAIL fwd_reply got %h exp 5c", bus.mcu_dout); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.tgt_strobe !== 4'b0) begin errors++; $display("FAIL fwd_single_pulse got %b exp 0000", bus.tgt_strobe); end
  endtask

  task automatic test_drop();
    bus.tgt_dout = 32'h5A5A_5A5A;
    step(1'b1, 1'b1, 8'h07);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    checks++; if (bus.tgt_strobe !== 4'b0 || bus.mcu_dout !== 8'hFF || busy !== 1'b1 || sel !== 3'd7) begin errors++;
      $display("FAIL drop got stb=%b dout=%h busy=%b sel=%0d exp 0000/ff/1/7", bus.tgt_strobe, bus.mcu_dout, busy, sel); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    checks++; if (busy !== 1'b1 || bus.mcu_dout !== 8'hFF) begin errors++;
      $display("FAIL drop_hold got busy=%b dout=%h exp 1/ff", busy, bus.mcu_dout); end
  endtask

  task automatic test_reframe();
    step(1'b1, 1'b1, 8'hF2);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h11);
    checks++; if (bus.tgt_strobe !== 4'b0100 || bus.tgt_start !== 4'b0100 || sel !== TGT_SDC) begin errors++;
      $display("FAIL reframe_t2 got stb=%b st=%b sel=%0d exp 0100/0100/2", bus.tgt_strobe, bus.tgt_start, sel); end
    step(1'b1, 1'b1, 8'h01);
    checks++; if (bus.tgt_strobe !== 4'b0 || abort !== 1'b0 || sel !== TGT_HID) begin errors++;
      $display("FAIL reframe_start got stb=%b abort=%b sel=%0d exp 0000/0/1", bus.tgt_strobe, abort, sel); end
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h22);
    checks++; if (bus.tgt_strobe !== 4'b0010 || bus.tgt_start !== 4'b0010 || bus.tgt_din !== 8'h22 || abort !== 1'b0) begin errors++;
      $display("FAIL reframe_t1 got stb=%b st=%b din=%h abort=%b exp 0010/0010/22/0", bus.tgt_strobe, bus.tgt_start, bus.tgt_din, abort); end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    step(1'b1, 1'b1, 8'h03);
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (abort === 1'b1) seen = k;
    end
    checks++; if (seen != TO - 1) begin errors++; $display("FAIL timeout_delay got %0d exp %0d", seen, TO - 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", abort); end
    seen = 0;
    step(1'b1, 1'b1, 8'h03);
    for (int k = 1; k < TO - 1; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (abort === 1'b1) seen = k;
    end
    step(1'b1, 1'b0, 8'h44);
    if (abort === 1'b1) seen = TO - 1;
    checks++; if (seen != 0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_saved got abort_at=%0d busy=%b exp 0/1", seen, busy); end
    for (int k = 1; k <= TO - 1; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (abort === 1'b1 && seen == 0) seen = k;
    end
    checks++; if (seen != TO - 1) begin errors++; $display("FAIL timeout_restart got %0d exp %0d", seen, TO - 1); end
  endtask

  task automatic test_interrupt();
    bus.tgt_int = 4'b0100;
    step(1'b0, 1'b0, 8'h00);
    checks++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL int_set got %b exp 0", int_out_n); end
    bus.tgt_int = 4'b0000;
    step(1'b0, 1'b0, 8'h00);
    checks++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL int_clr got %b exp 1", int_out_n); end
    bus.tgt_int = 4'b1000;
    step(1'b1, 1'b1, 8'h01);
    checks++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL int_frame got %b exp 0", int_out_n); end
    bus.tgt_int = 4'b0000;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h99);
    checks++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL int_frame_clr got %b exp 1", int_out_n); end
  endtask

  task automatic test_reset_midframe();
    bus.tgt_dout = 32'h1122_3344;
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    reset_n = 1'b0;
    step(1'b1, 1'b0, 8'h55);
    reset_n = 1'b1;
    checks++; if (busy !== 1'b0 || bus.mcu_dout !== 8'hFF || bus.tgt_strobe !== 4'b0) begin errors++;
      $display("FAIL rst_mid got busy=%b dout=%h stb=%b exp 0/ff/0000", busy, bus.mcu_dout, bus.tgt_strobe); end
    step(1'b1, 1'b1, 8'h03);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    checks++; if (bus.tgt_strobe !== 4'b1000 || bus.tgt_start !== 4'b1000 || bus.tgt_din !== 8'h77) begin errors++;
      $display("FAIL rst_after got stb=%b st=%b din=%h exp 1000/1000/77", bus.tgt_strobe, bus.tgt_start, bus.tgt_din); end
  endtask

  typedef struct {
    bit         stb;
    bit         st;
    logic [7:0] d;
  } act_t;

  task automatic test_random();
    act_t       acts[$];
    act_t       a;
    bit         open, settled, first;
    int         id;
    logic [7:0] last_din, exp_dout, exp_din;
    logic [3:0] exp_stb, exp_st;
    logic       exp_int_n;
    for (int f = 0; f < 14; f++) begin
      a.stb = 1'b1; a.st = 1'b1; a.d = 8'($urandom);
      acts.push_back(a);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin a.stb = 1'b0; a.st = 1'b0; acts.push_back(a); end
      for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
        a.stb = 1'b1; a.st = 1'b0; a.d = 8'($urandom);
        acts.push_back(a);
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin a.stb = 1'b0; a.st = 1'b0; acts.push_back(a); end
      end
    end
    reset_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    open = 0; settled = 0; first = 0; id = 0; last_din = 8'h00;
    foreach (acts[i]) begin
      a = acts[i];
      bus.tgt_dout = $urandom;
      bus.tgt_int  = 4'($urandom);
      exp_int_n = ~(|bus.tgt_int);
      exp_dout  = (open && settled && id < NT) ? bus.tgt_dout[8*id +: 8] : 8'hFF;
      exp_stb   = 4'b0;
      exp_st    = 4'b0;
      if (a.stb && a.st) begin
        open = 1; id = int'(a.d[2:0]); settled = 0; first = 1;
      end else if (a.stb && open && settled && id < NT) begin
        exp_stb  = 4'(1 << id);
        exp_st   = first ? 4'(1 << id) : 4'b0;
        last_din = a.d;
        first    = 0;
      end else if (!a.stb && open) begin
        settled = 1;
      end
      exp_din = last_din;
      step(a.stb, a.st, a.d);
      checks++; if (bus.tgt_strobe !== exp_stb || bus.tgt_start !== exp_st) begin errors++;
        $display("FAIL rnd_strobe[%0d] got %b/%b exp %b/%b", i, bus.tgt_strobe, bus.tgt_start, exp_stb, exp_st); end
      checks++; if (bus.tgt_din !== exp_din) begin errors++;
        $display("FAIL rnd_din[%0d] got %h exp %h", i, bus.tgt_din, exp_din); end
      checks++; if (bus.mcu_dout !== exp_dout) begin errors++;
        $display("FAIL rnd_dout[%0d] got %h exp %h", i, bus.mcu_dout, exp_dout); end
      checks++; if (int_out_n !== exp_int_n || abort !== 1'b0) begin errors++;
        $display("FAIL rnd_int_abort[%0d] got %b/%b exp %b/0", i, int_out_n, abort, exp_int_n); end
      checks++; if (busy !== open || (open && sel !== 3'(id))) begin errors++;
        $display("FAIL rnd_busy_sel[%0d] got %b/%0d exp %b/%0d", i, busy, sel, open, id); end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.mcu_strobe = 1'b0;
    bus.mcu_start  = 1'b0;
    bus.mcu_din    = 8'h00;
    bus.tgt_dout   = '0;
    bus.tgt_int    = '0;
    @(negedge clk);
    test_reset();
    test_forward_basic();
    test_drop();
    test_reframe();
    test_timeout();
    test_interrupt();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
